// File: rtl/serial_add_sched.sv
// serial_add_sched: round-robin arbiter for two requesters sharing one
// bit-serial full-adder slice; WIDTH cycles per job, LSB first.
module serial_add_sched #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] in0_a,
   input  logic [WIDTH-1:0] in0_b,
   input  logic             req1,
   input  logic [WIDTH-1:0] in1_a,
   input  logic [WIDTH-1:0] in1_b,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             done,
   output logic             owner,
   output logic [WIDTH-1:0] out,
   output logic             car
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   logic             r_lp;

   logic             r_gnt0;
   logic             r_gnt1;
   logic             r_done;
   logic             r_owner;
   logic [WIDTH-1:0] r_out;
   logic             r_car;

   logic             w_p;
   logic             w_g;
   logic             w_s;
   logic             w_t;
   logic             w_cn;
   logic             w_any;
   logic             w_win;
   logic             w_last;
   logic             w_load;
   logic             w_run;

   // full-adder slice: two half adders, carry merged by an OR
   assign w_p  = r_a[0] ^ r_b[0];
   assign w_g  = r_a[0] & r_b[0];
   assign w_s  = w_p ^ r_c;
   assign w_t  = w_p & r_c;
   assign w_cn = w_g | w_t;

   assign w_last = (r_cnt == CW'(WIDTH - 1));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_any)  w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // arbitration decode: contested grant goes to the one not served last
   always_comb begin
      w_any  = req0 | req1;
      w_win  = (req0 & req1) ? ~r_lp : req1;
      w_load = (r_state == S_IDLE) & w_any;
      w_run  = (r_state == S_RUN);
   end

   // grant/done pulses, operand capture and serial datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_done  <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_c     <= 1'b0;
         r_cnt   <= '0;
         r_lp    <= 1'b1;
         r_owner <= 1'b0;
         r_out   <= '0;
         r_car   <= 1'b0;
      end else begin
         r_gnt0 <= w_load & ~w_win;
         r_gnt1 <= w_load & w_win;
         r_done <= w_run & w_last;
         if (w_load) begin
            r_a     <= w_win ? in1_a : in0_a;
            r_b     <= w_win ? in1_b : in0_b;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_owner <= w_win;
            r_lp    <= w_win;
         end else if (w_run) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_c   <= w_cn;
            r_cnt <= r_cnt + CW'(1);
            r_res <= {w_s, r_res[WIDTH-1:1]};
            if (w_last) begin
               r_out <= {w_s, r_res[WIDTH-1:1]};
               r_car <= w_cn;
            end
         end
      end
   end

   assign gnt0  = r_gnt0;
   assign gnt1  = r_gnt1;
   assign done  = r_done;
   assign busy  = (r_state != S_IDLE);
   assign owner = r_owner;
   assign out   = r_out;
   assign car   = r_car;

endmodule

// File: tb/tb_serial_add_sched.sv
// tb_serial_add_sched: directed vector table plus hand sequences for
// contention, late arrival and mid-job reset.
module tb_serial_add_sched;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0 = 1'b0;
   logic         req1 = 1'b0;
   logic [W-1:0] in0_a = '0;
   logic [W-1:0] in0_b = '0;
   logic [W-1:0] in1_a = '0;
   logic [W-1:0] in1_b = '0;
   logic         gnt0;
   logic         gnt1;
   logic         busy;
   logic         done;
   logic         owner;
   logic [W-1:0] out;
   logic         car;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   serial_add_sched #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .in0_a(in0_a), .in0_b(in0_b),
      .req1(req1), .in1_a(in1_a), .in1_b(in1_b),
      .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
      .owner(owner), .out(out), .car(car)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // pulse exclusivity, every cycle out of reset
   always @(negedge clk) begin
      if (rst_n) begin
         chk("gnt_excl", int'(gnt0 & gnt1), 0);
         chk("gnt_done_excl", int'(done & (gnt0 | gnt1)), 0);
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // drive one job, expect grant next cycle and done 8 cycles after it
   task automatic do_job(
      input logic r0, input logic [W-1:0] a0, input logic [W-1:0] b0,
      input logic r1, input logic [W-1:0] a1, input logic [W-1:0] b1,
      input logic e_own, input logic [W-1:0] e_out, input logic e_car,
      input string nm);
      int n;
      bit seen;
      @(negedge clk);
      req0 = r0; in0_a = a0; in0_b = b0;
      req1 = r1; in1_a = a1; in1_b = b1;
      n = 0; seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n++;
         if (gnt0 | gnt1) begin seen = 1; break; end
      end
      chk({nm, "_gnt_lat"}, seen ? n : -1, 1);
      chk({nm, "_gnt_who"}, int'(gnt1), int'(e_own));
      chk({nm, "_busy"}, int'(busy), 1);
      if (gnt0) begin
         req0 = 1'b0; in0_a = 8'hA5; in0_b = 8'h5A;
      end else if (gnt1) begin
         req1 = 1'b0; in1_a = 8'hC3; in1_b = 8'h3C;
      end
      n = 0; seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         n++;
         if (done) begin seen = 1; break; end
      end
      chk({nm, "_done_lat"}, seen ? n : -1, 8);
      chk({nm, "_out"}, int'(out), int'(e_out));
      chk({nm, "_car"}, int'(car), int'(e_car));
      chk({nm, "_owner"}, int'(owner), int'(e_own));
   endtask

   typedef struct {
      bit           rst;
      bit           r0;
      logic [W-1:0] a0;
      logic [W-1:0] b0;
      bit           r1;
      logic [W-1:0] a1;
      logic [W-1:0] b1;
      bit           e_own;
      logic [W-1:0] e_out;
      bit           e_car;
   } vec_t;

   vec_t vt[9];

   initial begin
      int n;
      bit seen;
      int tg;
      int tp;

      vt[0] = '{0, 1, 8'h3C, 8'h05, 0, 8'h00, 8'h00, 0, 8'h41, 0};
      vt[1] = '{0, 0, 8'h00, 8'h00, 1, 8'hFF, 8'h01, 1, 8'h00, 1};
      vt[2] = '{0, 0, 8'h00, 8'h00, 1, 8'hFF, 8'hFF, 1, 8'hFE, 1};
      vt[3] = '{0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 0};
      vt[4] = '{0, 1, 8'hA5, 8'h5A, 0, 8'h00, 8'h00, 0, 8'hFF, 0};
      vt[5] = '{0, 0, 8'h00, 8'h00, 1, 8'h80, 8'h80, 1, 8'h00, 1};
      vt[6] = '{0, 1, 8'h01, 8'hFF, 0, 8'h00, 8'h00, 0, 8'h00, 1};
      vt[7] = '{1, 1, 8'h10, 8'h20, 1, 8'h7F, 8'h01, 0, 8'h30, 0};
      vt[8] = '{0, 0, 8'h00, 8'h00, 1, 8'h7F, 8'h01, 1, 8'h80, 0};

      // reset values
      #2;
      chk("rst_gnt0", int'(gnt0), 0);
      chk("rst_gnt1", int'(gnt1), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_owner", int'(owner), 0);
      chk("rst_out", int'(out), 0);
      chk("rst_car", int'(car), 0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) n++;
      end
      chk("idle_busy_cycles", n, 0);

      for (int k = 0; k < 9; k++) begin
         if (vt[k].rst) do_reset();
         do_job(vt[k].r0, vt[k].a0, vt[k].b0,
                vt[k].r1, vt[k].a1, vt[k].b1,
                vt[k].e_own, vt[k].e_out, vt[k].e_car,
                $sformatf("vec%0d", k));
      end

      // both held for four jobs: alternating owners, grants 10 apart
      do_reset();
      @(negedge clk);
      req0 = 1'b1; in0_a = 8'h11; in0_b = 8'h22;
      req1 = 1'b1; in1_a = 8'h40; in1_b = 8'hC1;
      tp = 0;
      for (int k = 0; k < 4; k++) begin
         seen = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt0 | gnt1) begin seen = 1; break; end
         end
         tg = cyc;
         chk($sformatf("b2b%0d_gnt", k), seen ? int'(gnt1) : -1, k % 2);
         if (k > 0) chk($sformatf("b2b%0d_gap", k), tg - tp, 10);
         tp = tg;
         seen = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
         end
         chk($sformatf("b2b%0d_done", k), int'(seen), 1);
         chk($sformatf("b2b%0d_owner", k), int'(owner), k % 2);
         chk($sformatf("b2b%0d_out", k), int'(out),
             (k % 2) ? 32'h01 : 32'h33);
         chk($sformatf("b2b%0d_car", k), int'(car), (k % 2) ? 1 : 0);
      end
      req0 = 1'b0;
      req1 = 1'b0;

      // late arrival of req1 during req0's job
      do_reset();
      @(negedge clk);
      req0 = 1'b1; in0_a = 8'h12; in0_b = 8'h34;
      @(negedge clk);
      chk("late_gnt0", int'(gnt0), 1);
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      req1 = 1'b1; in1_a = 8'h01; in1_b = 8'h02;
      seen = 0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (gnt1) n++;
         if (done) begin seen = 1; break; end
      end
      chk("late_no_early_gnt1", n, 0);
      chk("late_done0", int'(seen), 1);
      chk("late_out0", int'(out), 32'h46);
      chk("late_owner0", int'(owner), 0);
      n = 0; seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n++;
         if (gnt1) begin seen = 1; break; end
      end
      chk("late_gnt1_lat", seen ? n : -1, 2);
      req1 = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin seen = 1; break; end
      end
      chk("late_done1", int'(seen), 1);
      chk("late_out1", int'(out), 32'h03);
      chk("late_owner1", int'(owner), 1);

      // reset in the 4th RUN cycle aborts the job
      @(negedge clk);
      req0 = 1'b1; in0_a = 8'h55; in0_b = 8'h11;
      @(negedge clk);
      chk("mid_gnt0", int'(gnt0), 1);
      req0 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_busy", int'(busy), 0);
      chk("mid_out", int'(out), 0);
      chk("mid_car", int'(car), 0);
      chk("mid_owner", int'(owner), 0);
      chk("mid_pulses", int'(done | gnt0 | gnt1), 0);
      n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) n++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("mid_no_done", n, 0);
      do_job(1, 8'h01, 8'h01, 0, 8'h00, 8'h00, 0, 8'h02, 0, "post_rst");

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
